multi_commit_stage: RTL and testbench
=====================================

MULTI_COMMIT_STAGE -- requirements
Module: multi_commit_stage

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of retire ports (legal 1..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register write-data width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush_i  input  1  pipeline flush from controller.
REQ-007 SHALL have port debug_mode_i  input  1  when high, no new retirement starts.
REQ-008 SHALL have port instr_valid_i  input  NR_COMMIT_PORTS  per-port entry present, port 0 oldest.
REQ-009 SHALL have port instr_i  input  NR_COMMIT_PORTS x scoreboard_entry_t  oldest-first scoreboard entries.
REQ-010 SHALL have port commit_ack_o  output  NR_COMMIT_PORTS  per-port retire acknowledge.
REQ-011 SHALL have ports reg_w_en_o  output  NR_COMMIT_PORTS; reg_w_no_o  output  NR_COMMIT_PORTS x REG_ADDR_WIDTH; reg_w_data_o  output  NR_COMMIT_PORTS x DATA_WIDTH  register-file writes.
REQ-012 SHALL have ports store_commit_valid_o  output  1; store_commit_ready_i  input  1  store-buffer release handshake.
REQ-013 SHALL have ports csr_valid_o  output  1; csr_done_i  input  1; exception_o  output  exception_t  CSR-unit handoff.
REQ-014 SHALL have ports mispredict_o  output  1; predict_result_o  output  predict_t  registered branch resolution.
REQ-015 SHALL have port instret_o  output  $clog2(NR_COMMIT_PORTS+1)  instructions retired this cycle.

Function
REQ-016 Port k SHALL ack only if ports 0..k-1 ack this cycle, instr_valid_i[k]=1 and instr_i[k].result.valid=1 (strict in-order).
REQ-017 FU_ALU/FU_LOAD entries SHALL retire same cycle in RUN: reg_w_en_o[k]=1, reg_w_no_o[k]/reg_w_data_o[k] from result; zero-latency.
REQ-018 FU_CSR, FU_STORE and any entry with ex.valid=1 SHALL retire only on port 0; on port k>0 they stop retirement at k.
REQ-019 Branch (PREDICT_TAKEN): taken = result.value[0]; jalr (PREDICT_TARGET): target = ex.tval; mispredict when differing from instr_i[k].predict.
REQ-020 A mispredicting port k SHALL retire, block ports >k that cycle, and next cycle assert mispredict_o=1 for exactly one cycle with predict_result_o holding the corrected prediction.
REQ-021 FSM states SHALL be RUN, WAIT_STORE, WAIT_CSR, WAIT_FLUSH.
REQ-022 RUN, store on port 0: store_commit_valid_o=1; ready=1 same cycle -> ack, stay RUN; else -> WAIT_STORE, hold valid, ack in cycle ready=1, return RUN.
REQ-023 RUN, FU_CSR on port 0: csr_valid_o=1 one cycle, -> WAIT_CSR; ack port 0 in cycle csr_done_i=1, return RUN.
REQ-024 RUN, ex.valid on port 0: ack port 0, csr_valid_o=1, exception_o=instr_i[0].ex for one cycle, -> WAIT_FLUSH; no acks until flush_i.
REQ-025 exception_o SHALL be all-zero whenever csr_valid_o=0 or the port-0 entry is not an exception.
REQ-026 In WAIT_* states ports >0 SHALL never ack.
REQ-027 flush_i=1 SHALL force zero acks/writes that cycle, clear pending mispredict_o, and return FSM to RUN from any state; flush has priority over store ready and csr_done_i.
REQ-028 debug_mode_i=1 SHALL block new retirement in RUN; an in-progress WAIT_STORE/WAIT_CSR SHALL still complete.
REQ-029 instret_o SHALL equal popcount(commit_ack_o) every cycle.

Reset
REQ-030 rst_i=1 at a clock edge SHALL set FSM to RUN and clear the mispredict register; mid-handshake reset SHALL abandon the handshake without ack.
REQ-031 During and after reset until new input, all outputs SHALL be 0 (acks, write enables, store/csr valids, mispredict_o, predict_result_o, exception_o, instret_o).

Structure
REQ-032 commit_state_e and default NR_COMMIT_PORTS constant SHALL live in tortoise_pkg; data/addr types from riscv_pkg.
REQ-033 Per-port branch check SHALL be sub-module commit_branch_check, instantiated NR_COMMIT_PORTS times.

Verification
REQ-034 Two valid ALU entries, regs 3/4, data 0x11/0x22 -> commit_ack_o=2'b11, both writes, instret_o=2.
REQ-035 Port0 branch predicted taken, result.value[0]=0, port1 valid ALU -> ack=2'b01; next cycle mispredict_o=1, predict_result_o.is_taken=0.
REQ-036 Port0 store, store_commit_ready_i low 3 cycles then high -> store_commit_valid_o high 4 cycles, ack[0] only in 4th.
REQ-037 Port0 ex.valid=1 cause 2 -> ack[0]=1, csr_valid_o=1, exception_o.cause=2; no acks until flush_i, then RUN.
REQ-038 WAIT_CSR with rst_i=1 -> FSM RUN, all outputs 0, no ack of the CSR entry.
REQ-039 Port1 holds FU_CSR, port0 ALU -> ack=2'b01; next cycle CSR on port 0 enters WAIT_CSR.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: register data/index widths and the
// scoreboard entry layout consumed by the commit stage.
package riscv_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned REG_ADDR_BITS = 5;

  typedef logic [XLEN-1:0]          xlen_t;
  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_LOAD,
    FU_STORE,
    FU_BRANCH,
    FU_CSR
  } fu_t;

  typedef enum logic [1:0] {
    PREDICT_NONE,
    PREDICT_TAKEN,
    PREDICT_TARGET
  } predict_kind_e;

  typedef struct packed {
    predict_kind_e kind;
    logic          is_taken;
    xlen_t         target;
  } predict_t;

  typedef struct packed {
    logic  valid;
    xlen_t cause;
    xlen_t tval;
  } exception_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    xlen_t     value;
  } result_t;

  typedef struct packed {
    fu_t        fu;
    result_t    result;
    exception_t ex;
    predict_t   predict;
  } scoreboard_entry_t;

endpackage

// File: rtl/tortoise_pkg.sv
// Core-level configuration shared by the tortoise pipeline: commit FSM
// state encoding and default retire width.
package tortoise_pkg;

  localparam int unsigned DEFAULT_NR_COMMIT_PORTS = 2;

  typedef enum logic [1:0] {
    RUN,
    WAIT_STORE,
    WAIT_CSR,
    WAIT_FLUSH
  } commit_state_e;

endpackage

// File: rtl/commit_branch_check.sv
// Compares the resolved outcome of one retiring control-flow entry against
// its front-end prediction and produces the corrected prediction.
module commit_branch_check
  import riscv_pkg::*;
(
  input  predict_t predict,
  input  logic     actual_taken,
  input  xlen_t    actual_target,
  output logic     mispredict,
  output predict_t resolved
);

  always_comb begin
    resolved   = predict;
    mispredict = 1'b0;
    unique case (predict.kind)
      PREDICT_TAKEN: begin
        resolved.is_taken = actual_taken;
        mispredict        = (actual_taken != predict.is_taken);
      end
      PREDICT_TARGET: begin
        resolved.target = actual_target;
        mispredict      = (actual_target != predict.target);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_commit_stage.sv
// In-order multi-port commit stage: retires oldest-first scoreboard entries,
// sequences store/CSR/exception handshakes and reports branch mispredicts.
module multi_commit_stage
  import riscv_pkg::*;
  import tortoise_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = DEFAULT_NR_COMMIT_PORTS,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned REG_ADDR_WIDTH  = 5
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            flush_i,
  input  logic                                            debug_mode_i,
  input  logic              [NR_COMMIT_PORTS-1:0]         instr_valid_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]         instr_i,
  output logic              [NR_COMMIT_PORTS-1:0]         commit_ack_o,
  output logic              [NR_COMMIT_PORTS-1:0]         reg_w_en_o,
  output logic [NR_COMMIT_PORTS-1:0][REG_ADDR_WIDTH-1:0]  reg_w_no_o,
  output logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]      reg_w_data_o,
  output logic                                            store_commit_valid_o,
  input  logic                                            store_commit_ready_i,
  output logic                                            csr_valid_o,
  input  logic                                            csr_done_i,
  output exception_t                                      exception_o,
  output logic                                            mispredict_o,
  output predict_t                                        predict_result_o,
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]            instret_o
);

  localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS + 1);

  commit_state_e state_q, state_n;
  logic          mispredict_q, mispredict_n;
  predict_t      predict_q, predict_n;

  logic     [NR_COMMIT_PORTS-1:0] ready;
  logic     [NR_COMMIT_PORTS-1:0] special;
  logic     [NR_COMMIT_PORTS-1:0] mis;
  predict_t [NR_COMMIT_PORTS-1:0] resolved;
  logic     [NR_COMMIT_PORTS-1:0] ack;
  logic     [NR_COMMIT_PORTS-1:0] unused_cause;
  logic                           go;
  logic                           hold;

  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_port
    assign ready[k]   = instr_valid_i[k] & instr_i[k].result.valid;
    assign special[k] = instr_i[k].ex.valid
                      | (instr_i[k].fu == FU_CSR)
                      | (instr_i[k].fu == FU_STORE);
    assign unused_cause[k] = ^instr_i[k].ex.cause;

    commit_branch_check u_check (
      .predict       (instr_i[k].predict),
      .actual_taken  (instr_i[k].result.value[0]),
      .actual_target (instr_i[k].ex.tval),
      .mispredict    (mis[k]),
      .resolved      (resolved[k])
    );
  end

  // Reset is folded in with flush so outputs are quiet during reset cycles.
  assign hold = rst_i | flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      mispredict_q <= 1'b0;
      predict_q    <= '0;
    end else begin
      state_q      <= state_n;
      mispredict_q <= mispredict_n;
      predict_q    <= predict_n;
    end
  end

  always_comb begin
    state_n              = state_q;
    ack                  = '0;
    store_commit_valid_o = 1'b0;
    csr_valid_o          = 1'b0;
    exception_o          = '0;
    mispredict_n         = 1'b0;
    predict_n            = '0;
    go                   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (!hold && !debug_mode_i && ready[0]) begin
          if (instr_i[0].ex.valid) begin
            ack[0]      = 1'b1;
            csr_valid_o = 1'b1;
            exception_o = instr_i[0].ex;
            state_n     = WAIT_FLUSH;
          end else if (instr_i[0].fu == FU_CSR) begin
            csr_valid_o = 1'b1;
            state_n     = WAIT_CSR;
          end else if (instr_i[0].fu == FU_STORE) begin
            store_commit_valid_o = 1'b1;
            if (store_commit_ready_i) begin
              ack[0] = 1'b1;
              go     = 1'b1;
            end else begin
              state_n = WAIT_STORE;
            end
          end else begin
            ack[0] = 1'b1;
            go     = !mis[0];
            if (mis[0]) begin
              mispredict_n = 1'b1;
              predict_n    = resolved[0];
            end
          end

          // Younger ports retire only behind an unbroken run of plain acks.
          for (int unsigned k = 1; k < NR_COMMIT_PORTS; k++) begin
            if (go && ready[k] && !special[k]) begin
              ack[k] = 1'b1;
              if (mis[k]) begin
                go           = 1'b0;
                mispredict_n = 1'b1;
                predict_n    = resolved[k];
              end
            end else begin
              go = 1'b0;
            end
          end
        end
      end
      WAIT_STORE: begin
        if (hold) begin
          state_n = RUN;
        end else begin
          store_commit_valid_o = 1'b1;
          if (store_commit_ready_i) begin
            ack[0]  = 1'b1;
            state_n = RUN;
          end
        end
      end
      WAIT_CSR: begin
        if (hold) begin
          state_n = RUN;
        end else if (csr_done_i) begin
          ack[0]  = 1'b1;
          state_n = RUN;
        end
      end
      WAIT_FLUSH: begin
        if (hold) state_n = RUN;
      end
    endcase
  end

  always_comb begin
    reg_w_en_o   = '0;
    reg_w_no_o   = '0;
    reg_w_data_o = '0;
    instret_o    = '0;
    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (ack[k] && !instr_i[k].ex.valid &&
          (instr_i[k].fu == FU_ALU || instr_i[k].fu == FU_LOAD)) begin
        reg_w_en_o[k]   = 1'b1;
        reg_w_no_o[k]   = REG_ADDR_WIDTH'(instr_i[k].result.rd);
        reg_w_data_o[k] = DATA_WIDTH'(instr_i[k].result.value);
      end
      instret_o = instret_o + CNT_W'(ack[k]);
    end
  end

  assign commit_ack_o     = ack;
  assign mispredict_o     = mispredict_q;
  assign predict_result_o = predict_q;

endmodule

// File: tb/tb_multi_commit_stage.sv
// Directed self-checking bench for multi_commit_stage with two retire ports.
module tb_multi_commit_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, debug;
  logic [1:0] valid;
  scoreboard_entry_t [1:0] instr;
  logic [1:0] ack, wen;
  logic [1:0][4:0] wno;
  logic [1:0][63:0] wdata;
  logic st_valid, st_ready, csr_valid, csr_done, mp;
  exception_t exc;
  predict_t pr;
  logic [1:0] instret;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_commit_stage #(
    .NR_COMMIT_PORTS (2),
    .DATA_WIDTH      (64),
    .REG_ADDR_WIDTH  (5)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .debug_mode_i         (debug),
    .instr_valid_i        (valid),
    .instr_i              (instr),
    .commit_ack_o         (ack),
    .reg_w_en_o           (wen),
    .reg_w_no_o           (wno),
    .reg_w_data_o         (wdata),
    .store_commit_valid_o (st_valid),
    .store_commit_ready_i (st_ready),
    .csr_valid_o          (csr_valid),
    .csr_done_i           (csr_done),
    .exception_o          (exc),
    .mispredict_o         (mp),
    .predict_result_o     (pr),
    .instret_o            (instret)
  );

  function automatic scoreboard_entry_t mk(fu_t fu, reg_addr_t rd, xlen_t v);
    scoreboard_entry_t e;
    e = '0;
    e.fu = fu;
    e.result.valid = 1'b1;
    e.result.rd = rd;
    e.result.value = v;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0; instr = '0; flush = 1'b0; debug = 1'b0;
    st_ready = 1'b0; csr_done = 1'b0;
  endtask

  task automatic alu_pair();
    valid = 2'b11;
    instr[0] = mk(FU_ALU, 5'd3, 64'h11);
    instr[1] = mk(FU_ALU, 5'd4, 64'h22);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); alu_pair();
    cyc(); cyc();
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_checks++; if (wen !== 2'b00) begin n_fail++; $display("FAIL reset_wen: got %b want 00", wen); end
    n_checks++; if (instret !== 2'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
    n_checks++; if ({st_valid, csr_valid, mp} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {st_valid, csr_valid, mp}); end
    n_checks++; if (pr !== '0) begin n_fail++; $display("FAIL reset_predict: got %h want 0", pr); end
    n_checks++; if (exc !== '0) begin n_fail++; $display("FAIL reset_exception: got %h want 0", exc); end
    cyc(); rst = 1'b0; idle();
    @(negedge clk);
    n_checks++; if ({ack, mp, st_valid, csr_valid} !== 5'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00000", {ack, mp, st_valid, csr_valid}); end
  endtask

  task automatic test_dual_alu();
    cyc(); idle(); alu_pair();
    @(negedge clk);
    n_checks++; if (ack !== 2'b11) begin n_fail++; $display("FAIL alu_ack: got %b want 11", ack); end
    n_checks++; if (wen !== 2'b11) begin n_fail++; $display("FAIL alu_wen: got %b want 11", wen); end
    n_checks++; if (wno[0] !== 5'd3 || wno[1] !== 5'd4) begin n_fail++; $display("FAIL alu_wno: got %0d/%0d want 3/4", wno[0], wno[1]); end
    n_checks++; if (wdata[0] !== 64'h11 || wdata[1] !== 64'h22) begin n_fail++; $display("FAIL alu_wdata: got %h/%h want 11/22", wdata[0], wdata[1]); end
    n_checks++; if (instret !== 2'd2) begin n_fail++; $display("FAIL alu_instret: got %0d want 2", instret); end
  endtask

  task automatic test_in_order();
    cyc(); idle(); alu_pair(); instr[0].result.valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL order_unready0: got %b want 00", ack); end
    cyc(); idle(); alu_pair(); valid = 2'b10;
    @(negedge clk);
    n_checks++; if ({ack, instret} !== 4'b0) begin n_fail++; $display("FAIL order_invalid0: got %b/%0d want 00/0", ack, instret); end
    cyc(); idle(); alu_pair(); instr[1] = mk(FU_STORE, 5'd0, 64'h0); st_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({ack, st_valid} !== 3'b010) begin n_fail++; $display("FAIL order_store_port1: got %b want 010", {ack, st_valid}); end
  endtask

  task automatic test_mispredict();
    cyc(); idle(); alu_pair();
    instr[0] = mk(FU_BRANCH, 5'd0, 64'h0);
    instr[0].predict.kind = PREDICT_TAKEN;
    instr[0].predict.is_taken = 1'b1;
    @(negedge clk);
    n_checks++; if ({ack, wen, mp} !== 5'b01000) begin n_fail++; $display("FAIL br_ack: got %b want 01000", {ack, wen, mp}); end
    cyc(); idle();
    @(negedge clk);
    n_checks++; if (mp !== 1'b1 || pr.is_taken !== 1'b0 || pr.kind !== PREDICT_TAKEN) begin n_fail++; $display("FAIL br_mispredict: got %b/%b want 1/0", mp, pr.is_taken); end
    cyc();
    @(negedge clk);
    n_checks++; if (mp !== 1'b0) begin n_fail++; $display("FAIL br_one_cycle: got %b want 0", mp); end
    cyc(); idle(); alu_pair();
    instr[1] = mk(FU_BRANCH, 5'd1, 64'h0);
    instr[1].predict.kind = PREDICT_TARGET;
    instr[1].predict.target = 64'h100;
    instr[1].ex.tval = 64'h200;
    @(negedge clk);
    n_checks++; if ({ack, wen, instret} !== 6'b110110) begin n_fail++; $display("FAIL jalr1_ack: got %b want 110110", {ack, wen, instret}); end
    cyc(); idle();
    @(negedge clk);
    n_checks++; if (mp !== 1'b1 || pr.target !== 64'h200) begin n_fail++; $display("FAIL jalr1_target: got %b/%h want 1/200", mp, pr.target); end
    cyc(); idle(); valid = 2'b01;
    instr[0] = mk(FU_BRANCH, 5'd1, 64'h0);
    instr[0].predict.kind = PREDICT_TARGET;
    instr[0].predict.target = 64'h300;
    instr[0].ex.tval = 64'h300;
    cyc(); idle();
    @(negedge clk);
    n_checks++; if (mp !== 1'b0) begin n_fail++; $display("FAIL jalr_correct: got %b want 0", mp); end
  endtask

  task automatic test_store();
    cyc(); idle(); valid = 2'b01; instr[0] = mk(FU_STORE, 5'd0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      st_ready = (i == 3);
      @(negedge clk);
      n_checks++;
      if (st_valid !== 1'b1 || ack !== ((i == 3) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL store_wait%0d: got valid=%b ack=%b want 1/%b", i, st_valid, ack, (i == 3) ? 2'b01 : 2'b00);
      end
    end
    cyc(); idle(); alu_pair();
    @(negedge clk);
    n_checks++; if ({st_valid, ack} !== 3'b011) begin n_fail++; $display("FAIL store_back_run: got %b want 011", {st_valid, ack}); end
  endtask

  task automatic test_exception();
    cyc(); idle(); valid = 2'b01;
    instr[0] = mk(FU_ALU, 5'd1, 64'h0);
    instr[0].ex.valid = 1'b1;
    instr[0].ex.cause = 64'd2;
    @(negedge clk);
    n_checks++; if ({ack, csr_valid, wen} !== 5'b01100) begin n_fail++; $display("FAIL exc_ack: got %b want 01100", {ack, csr_valid, wen}); end
    n_checks++; if (exc.valid !== 1'b1 || exc.cause !== 64'd2) begin n_fail++; $display("FAIL exc_cause: got %b/%0d want 1/2", exc.valid, exc.cause); end
    cyc(); idle(); alu_pair();
    @(negedge clk);
    n_checks++; if ({ack, csr_valid} !== 3'b000 || exc !== '0) begin n_fail++; $display("FAIL exc_wait: got %b exc=%h want 000 exc=0", {ack, csr_valid}, exc); end
    cyc(); flush = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL exc_flush: got %b want 00", ack); end
    cyc(); flush = 1'b0;
    @(negedge clk);
    n_checks++; if (ack !== 2'b11) begin n_fail++; $display("FAIL exc_resume: got %b want 11", ack); end
  endtask

  task automatic test_csr();
    cyc(); idle(); valid = 2'b11;
    instr[0] = mk(FU_ALU, 5'd7, 64'h77);
    instr[1] = mk(FU_CSR, 5'd8, 64'h88);
    @(negedge clk);
    n_checks++; if ({ack, csr_valid, wen} !== 5'b01001) begin n_fail++; $display("FAIL csr_port1: got %b want 01001", {ack, csr_valid, wen}); end
    cyc(); valid = 2'b01; instr[0] = instr[1];
    @(negedge clk);
    n_checks++; if ({ack, csr_valid} !== 3'b001 || exc !== '0) begin n_fail++; $display("FAIL csr_launch: got %b exc=%h want 001 exc=0", {ack, csr_valid}, exc); end
    cyc(); csr_done = 1'b1;
    @(negedge clk);
    n_checks++; if ({ack, csr_valid, instret} !== 5'b01001) begin n_fail++; $display("FAIL csr_done: got %b want 01001", {ack, csr_valid, instret}); end
    cyc(); csr_done = 1'b0;
    cyc(); rst = 1'b1; csr_done = 1'b1;
    @(negedge clk);
    n_checks++; if ({ack, csr_valid, st_valid, instret} !== 6'b0) begin n_fail++; $display("FAIL csr_reset: got %b want 000000", {ack, csr_valid, st_valid, instret}); end
    cyc(); rst = 1'b0; csr_done = 1'b0;
    @(negedge clk);
    n_checks++; if ({ack, csr_valid} !== 3'b001) begin n_fail++; $display("FAIL csr_after_reset: got %b want 001", {ack, csr_valid}); end
    cyc(); idle(); flush = 1'b1;
  endtask

  task automatic test_debug_flush();
    cyc(); idle(); alu_pair(); debug = 1'b1;
    @(negedge clk);
    n_checks++; if ({ack, wen} !== 4'b0) begin n_fail++; $display("FAIL debug_block: got %b want 0000", {ack, wen}); end
    cyc(); idle(); valid = 2'b01; instr[0] = mk(FU_STORE, 5'd0, 64'h0);
    cyc(); debug = 1'b1; st_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL debug_store_done: got %b want 01", ack); end
    cyc(); idle(); valid = 2'b01; instr[0] = mk(FU_STORE, 5'd0, 64'h0);
    cyc(); flush = 1'b1; st_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL flush_priority: got %b want 00", ack); end
    cyc(); idle(); alu_pair();
    @(negedge clk);
    n_checks++; if (ack !== 2'b11) begin n_fail++; $display("FAIL flush_to_run: got %b want 11", ack); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_dual_alu();
    test_in_order();
    test_mispredict();
    test_store();
    test_exception();
    test_csr();
    test_debug_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
